// File: rtl/ethmac_ctrl_pkg.sv
// rtl/ethmac_ctrl_pkg.sv - shared types and widths for the ethmac control-plane blocks
package ethmac_ctrl_pkg;

    localparam int ETH_WB_DAT_W = 32;
    localparam int ETH_WB_SEL_W = 4;
    localparam int ETH_WB_ADR_W = 10;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUS,
        ARB_DONE
    } arb_state_t;

endpackage

// File: rtl/ethmac_wb_slave_arb_if.sv
// rtl/ethmac_wb_slave_arb_if.sv - requester and MAC-side signals of the register-port arbiter
interface ethmac_wb_slave_arb_if
    import ethmac_ctrl_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int ADR_W = ETH_WB_ADR_W
);
    logic [NREQ-1:0]              req_vld_i;
    logic [NREQ-1:0]              req_we_i;
    logic [NREQ*ADR_W-1:0]        req_adr_i;
    logic [NREQ*ETH_WB_SEL_W-1:0] req_sel_i;
    logic [NREQ*ETH_WB_DAT_W-1:0] req_dat_i;
    logic [NREQ-1:0]              req_ack_o;
    logic [NREQ-1:0]              req_err_o;
    logic [ETH_WB_DAT_W-1:0]      req_dat_o;
    logic [NREQ-1:0]              gnt_o;
    logic                         busy_o;
    logic                         timeout_o;

    logic [ADR_W-1:0]             eth_wb_adr_o;
    logic [ETH_WB_SEL_W-1:0]      eth_wb_sel_o;
    logic                         eth_wb_we_o;
    logic [ETH_WB_DAT_W-1:0]      eth_wb_dat_o;
    logic                         eth_wb_cyc_o;
    logic                         eth_wb_stb_o;
    logic [ETH_WB_DAT_W-1:0]      eth_wb_dat_i;
    logic                         eth_wb_ack_i;
    logic                         eth_wb_err_i;

    // master: the arbiter itself; slave: requesters plus the MAC register port
    modport master (
        input  req_vld_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
        output req_ack_o, req_err_o, req_dat_o, gnt_o, busy_o, timeout_o,
        output eth_wb_adr_o, eth_wb_sel_o, eth_wb_we_o, eth_wb_dat_o,
        output eth_wb_cyc_o, eth_wb_stb_o,
        input  eth_wb_dat_i, eth_wb_ack_i, eth_wb_err_i
    );

    modport slave (
        output req_vld_i, req_we_i, req_adr_i, req_sel_i, req_dat_i,
        input  req_ack_o, req_err_o, req_dat_o, gnt_o, busy_o, timeout_o,
        input  eth_wb_adr_o, eth_wb_sel_o, eth_wb_we_o, eth_wb_dat_o,
        input  eth_wb_cyc_o, eth_wb_stb_o,
        output eth_wb_dat_i, eth_wb_ack_i, eth_wb_err_i
    );

endinterface

// File: rtl/eth_rr_pick.sv
// rtl/eth_rr_pick.sv - combinational round-robin pick: first request at or after ptr, wrapping
module eth_rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx,
    output logic            vld
);

    logic [PW-1:0] cand;

    // Scan farthest-first so the candidate nearest the pointer overwrites the others.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = PW'((int'(ptr) + i) % NREQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                idx       = cand;
                vld       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ethmac_wb_slave_arb.sv
// rtl/ethmac_wb_slave_arb.sv - round-robin sharing of the ethmac WISHBONE register port
module ethmac_wb_slave_arb
    import ethmac_ctrl_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int ADR_W       = ETH_WB_ADR_W,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    ethmac_wb_slave_arb_if.master bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    arb_state_t              state;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           owner;
    logic [TW-1:0]           cnt;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         req_ack;
    logic [NREQ-1:0]         req_err;
    logic [ETH_WB_DAT_W-1:0] req_dat;
    logic                    busy;
    logic                    timeout;
    logic [ADR_W-1:0]        adr;
    logic [ETH_WB_SEL_W-1:0] sel;
    logic                    we;
    logic [ETH_WB_DAT_W-1:0] dat;
    logic                    cyc;
    logic                    stb;

    logic [NREQ-1:0]         pick_gnt;
    logic [PW-1:0]           pick_idx;
    logic                    pick_vld;
    logic                    to_hit;

    logic [ADR_W-1:0]        adr_arr [NREQ];
    logic [ETH_WB_SEL_W-1:0] sel_arr [NREQ];
    logic [ETH_WB_DAT_W-1:0] dat_arr [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            adr_arr[i] = bus.req_adr_i[i*ADR_W +: ADR_W];
            sel_arr[i] = bus.req_sel_i[i*ETH_WB_SEL_W +: ETH_WB_SEL_W];
            dat_arr[i] = bus.req_dat_i[i*ETH_WB_DAT_W +: ETH_WB_DAT_W];
        end
    end

    eth_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req  (bus.req_vld_i),
        .ptr  (ptr),
        .gnt  (pick_gnt),
        .idx  (pick_idx),
        .vld  (pick_vld)
    );

    // Count value TIMEOUT_CYC-1 is seen on the last allowed BUS cycle, so stb stays up TIMEOUT_CYC cycles.
    assign to_hit = (TIMEOUT_CYC > 0) && (cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state   <= ARB_IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            req_ack <= '0;
            req_err <= '0;
            req_dat <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            adr     <= '0;
            sel     <= '0;
            we      <= 1'b0;
            dat     <= '0;
            cyc     <= 1'b0;
            stb     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    req_ack <= '0;
                    req_err <= '0;
                    timeout <= 1'b0;
                    if (pick_vld) begin
                        state <= ARB_BUS;
                        owner <= pick_idx;
                        gnt   <= pick_gnt;
                        adr   <= adr_arr[pick_idx];
                        sel   <= sel_arr[pick_idx];
                        dat   <= dat_arr[pick_idx];
                        we    <= bus.req_we_i[pick_idx];
                        cyc   <= 1'b1;
                        stb   <= 1'b1;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                ARB_BUS: begin
                    if (bus.eth_wb_err_i || bus.eth_wb_ack_i || to_hit) begin
                        state <= ARB_DONE;
                        cyc   <= 1'b0;
                        stb   <= 1'b0;
                        gnt   <= '0;
                        if (bus.eth_wb_err_i || !bus.eth_wb_ack_i) begin
                            req_err[owner] <= 1'b1;
                            timeout        <= !bus.eth_wb_err_i;
                        end else begin
                            req_ack[owner] <= 1'b1;
                            if (!we) begin
                                req_dat <= bus.eth_wb_dat_i;
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB_DONE: begin
                    state   <= ARB_IDLE;
                    req_ack <= '0;
                    req_err <= '0;
                    timeout <= 1'b0;
                    busy    <= 1'b0;
                    ptr     <= PW'((int'(owner) + 1) % NREQ);
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ack_o    = req_ack;
    assign bus.req_err_o    = req_err;
    assign bus.req_dat_o    = req_dat;
    assign bus.gnt_o        = gnt;
    assign bus.busy_o       = busy;
    assign bus.timeout_o    = timeout;
    assign bus.eth_wb_adr_o = adr;
    assign bus.eth_wb_sel_o = sel;
    assign bus.eth_wb_we_o  = we;
    assign bus.eth_wb_dat_o = dat;
    assign bus.eth_wb_cyc_o = cyc;
    assign bus.eth_wb_stb_o = stb;

endmodule

// File: tb/tb_ethmac_wb_slave_arb.sv
// tb/tb_ethmac_wb_slave_arb.sv - directed self-checking bench for ethmac_wb_slave_arb
module tb_ethmac_wb_slave_arb;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n;

    ethmac_wb_slave_arb_if #(.NREQ(2), .ADR_W(10)) bus();

    ethmac_wb_slave_arb #(
        .NREQ        (2),
        .ADR_W       (10),
        .TIMEOUT_CYC (8)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic vld, input logic we,
                           input logic [9:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        bus.req_vld_i[i]          = vld;
        bus.req_we_i[i]           = we;
        bus.req_adr_i[i*10 +: 10] = adr;
        bus.req_sel_i[i*4 +: 4]   = sel;
        bus.req_dat_i[i*32 +: 32] = dat;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_vld_i = '0;
        bus.req_we_i  = '0;
        bus.req_adr_i = '0;
        bus.req_sel_i = '0;
        bus.req_dat_i = '0;
        bus.eth_wb_dat_i = '0;
        bus.eth_wb_ack_i = 1'b0;
        bus.eth_wb_err_i = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("rst_cyc", 32'(bus.eth_wb_cyc_o), 32'd0);
        chk("rst_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_dat", bus.req_dat_o, 32'd0);

        // single write from requester 0
        set_req(0, 1'b1, 1'b1, 10'h000, 4'hF, 32'h0000_A423);
        tick;
        chk("wr_cyc", 32'(bus.eth_wb_cyc_o), 32'd1);
        chk("wr_stb", 32'(bus.eth_wb_stb_o), 32'd1);
        chk("wr_gnt", 32'(bus.gnt_o), 32'd1);
        chk("wr_we", 32'(bus.eth_wb_we_o), 32'd1);
        chk("wr_dat", bus.eth_wb_dat_o, 32'h0000_A423);
        chk("wr_sel", 32'(bus.eth_wb_sel_o), 32'hF);
        bus.req_vld_i[0] = 1'b0;
        tick;
        chk("wr_hold_cyc", 32'(bus.eth_wb_cyc_o), 32'd1);
        bus.eth_wb_ack_i = 1'b1;
        tick;
        bus.eth_wb_ack_i = 1'b0;
        chk("wr_ack", 32'(bus.req_ack_o), 32'd1);
        chk("wr_err", 32'(bus.req_err_o), 32'd0);
        chk("wr_cyc_off", 32'(bus.eth_wb_cyc_o), 32'd0);
        chk("wr_gnt_off", 32'(bus.gnt_o), 32'd0);
        chk("wr_rdat", bus.req_dat_o, 32'd0);
        tick;
        chk("wr_ack_end", 32'(bus.req_ack_o), 32'd0);
        chk("wr_busy_end", 32'(bus.busy_o), 32'd0);

        // single read from requester 1
        set_req(1, 1'b1, 1'b0, 10'h010, 4'hF, 32'h0);
        tick;
        chk("rd_gnt", 32'(bus.gnt_o), 32'd2);
        chk("rd_adr", 32'(bus.eth_wb_adr_o), 32'h010);
        chk("rd_we", 32'(bus.eth_wb_we_o), 32'd0);
        bus.eth_wb_dat_i = 32'h0000_0040;
        bus.eth_wb_ack_i = 1'b1;
        tick;
        bus.eth_wb_ack_i = 1'b0;
        bus.eth_wb_dat_i = 32'hDEAD_BEEF;
        bus.req_vld_i[1] = 1'b0;
        chk("rd_ack", 32'(bus.req_ack_o), 32'd2);
        chk("rd_dat", bus.req_dat_o, 32'h0000_0040);
        tick;
        chk("rd_dat_hold", bus.req_dat_o, 32'h0000_0040);

        // contention: both requesters pending continuously, MAC acks immediately
        set_req(0, 1'b1, 1'b1, 10'h001, 4'h3, 32'h1111_2222);
        set_req(1, 1'b1, 1'b0, 10'h002, 4'hF, 32'h0);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!bus.eth_wb_stb_o && n < 8) begin
                tick;
                n++;
            end
            chk("ct_stb", 32'(bus.eth_wb_stb_o), 32'd1);
            if (k > 0) chk("ct_gap", 32'(n), 32'd2);
            chk("ct_gnt", 32'(bus.gnt_o), (k % 2 == 1) ? 32'd2 : 32'd1);
            bus.eth_wb_ack_i = 1'b1;
            tick;
            bus.eth_wb_ack_i = 1'b0;
            chk("ct_ack", 32'(bus.req_ack_o), (k % 2 == 1) ? 32'd2 : 32'd1);
        end
        bus.req_vld_i = '0;
        tick;
        chk("ct_rdat", bus.req_dat_o, 32'hDEAD_BEEF);

        // ack and err together on a read: err wins, read data untouched
        set_req(0, 1'b1, 1'b0, 10'h003, 4'hF, 32'h0);
        bus.eth_wb_dat_i = 32'h0000_1234;
        tick;
        chk("er_gnt", 32'(bus.gnt_o), 32'd1);
        bus.req_vld_i[0] = 1'b0;
        bus.eth_wb_ack_i = 1'b1;
        bus.eth_wb_err_i = 1'b1;
        tick;
        bus.eth_wb_ack_i = 1'b0;
        bus.eth_wb_err_i = 1'b0;
        chk("er_err", 32'(bus.req_err_o), 32'd1);
        chk("er_ack", 32'(bus.req_ack_o), 32'd0);
        chk("er_to", 32'(bus.timeout_o), 32'd0);
        chk("er_dat", bus.req_dat_o, 32'hDEAD_BEEF);
        tick;

        // timeout: MAC never answers requester 1
        set_req(1, 1'b1, 1'b0, 10'h004, 4'hF, 32'h0);
        tick;
        bus.req_vld_i[1] = 1'b0;
        n = 0;
        while (bus.eth_wb_stb_o && n < 20) begin
            n++;
            tick;
        end
        chk("to_len", 32'(n), 32'd8);
        chk("to_err", 32'(bus.req_err_o), 32'd2);
        chk("to_pulse", 32'(bus.timeout_o), 32'd1);
        chk("to_ack", 32'(bus.req_ack_o), 32'd0);
        bus.eth_wb_ack_i = 1'b1;
        tick;
        chk("to_late_ack", 32'(bus.req_ack_o), 32'd0);
        chk("to_pulse_end", 32'(bus.timeout_o), 32'd0);
        tick;
        chk("to_late_cyc", 32'(bus.eth_wb_cyc_o), 32'd0);
        chk("to_late_busy", 32'(bus.busy_o), 32'd0);
        bus.eth_wb_ack_i = 1'b0;

        // leave the pointer at 1, then reset in the middle of a bus cycle
        set_req(0, 1'b1, 1'b1, 10'h005, 4'hF, 32'h5);
        tick;
        bus.req_vld_i[0] = 1'b0;
        bus.eth_wb_ack_i = 1'b1;
        tick;
        bus.eth_wb_ack_i = 1'b0;
        tick;
        bus.req_vld_i = 2'b11;
        tick;
        chk("rs_gnt_pre", 32'(bus.gnt_o), 32'd2);
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk("rs_cyc", 32'(bus.eth_wb_cyc_o), 32'd0);
        chk("rs_stb", 32'(bus.eth_wb_stb_o), 32'd0);
        chk("rs_gnt", 32'(bus.gnt_o), 32'd0);
        chk("rs_ack", 32'(bus.req_ack_o), 32'd0);
        chk("rs_err", 32'(bus.req_err_o), 32'd0);
        bus.eth_wb_ack_i = 1'b1;
        rst = 1'b0;
        tick;
        chk("rs_regnt", 32'(bus.gnt_o), 32'd1);
        chk("rs_late_ack", 32'(bus.req_ack_o), 32'd0);
        tick;
        bus.eth_wb_ack_i = 1'b0;
        bus.req_vld_i = '0;
        chk("rs_done_ack", 32'(bus.req_ack_o), 32'd1);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
